// File: rtl/gecko_mem_arbiter_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// gecko_mem_arbiter_pkg : shared types for the two-requester memory arbiter
// Rev 1.0
//------------------------------------------------------------------------------
package gecko_mem_arbiter_pkg;

  typedef enum logic {
    GECKO_MEM_ARB_ROUND_ROBIN = 1'b0,
    GECKO_MEM_ARB_FIXED       = 1'b1
  } gecko_mem_arb_mode_t;

  typedef enum logic [1:0] {
    STD_TECHNOLOGY_FPGA_XILINX = 2'd0,
    STD_TECHNOLOGY_FPGA_INTEL  = 2'd1,
    STD_TECHNOLOGY_ASIC        = 2'd2
  } std_technology_t;

  typedef logic gecko_mem_arb_owner_t;

  localparam gecko_mem_arb_owner_t OWNER_PORT0 = 1'b0;
  localparam gecko_mem_arb_owner_t OWNER_PORT1 = 1'b1;

endpackage
`default_nettype wire

// File: rtl/gecko_mem_arbiter_order_queue.sv
`default_nettype none
//------------------------------------------------------------------------------
// gecko_mem_arbiter_order_queue : register FIFO of request owners, in issue order
// Rev 1.0
//------------------------------------------------------------------------------
module gecko_mem_arbiter_order_queue
  import gecko_mem_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             owner_i,
  output logic             head_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [CNT_W-1:0] count_o
);

  gecko_mem_arb_owner_t slots_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;

  // DEPTH is a power of two, so pointers wrap naturally on overflow
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) slots_q[wr_ptr_q] <= owner_i;
  end

  assign head_o  = slots_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/gecko_mem_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// gecko_mem_arbiter : shares one memory channel between two requesters
// Rev 1.0
//------------------------------------------------------------------------------
module gecko_mem_arbiter
  import gecko_mem_arbiter_pkg::*;
#(
  parameter                      CLOCK_INFO      = 'b0,
  parameter std_technology_t     TECHNOLOGY      = STD_TECHNOLOGY_FPGA_XILINX,
  parameter int                  ADDR_WIDTH      = 32,
  parameter int                  DATA_WIDTH      = 32,
  parameter int                  MAX_OUTSTANDING = 4,
  parameter gecko_mem_arb_mode_t ARB_MODE        = GECKO_MEM_ARB_ROUND_ROBIN,
  localparam int                 BE_W            = DATA_WIDTH / 8,
  localparam int                 CNT_W           = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid_i,
  output logic                  req0_ready_o,
  input  logic                  req0_read_write_i,
  input  logic [BE_W-1:0]       req0_write_enable_i,
  input  logic [ADDR_WIDTH-1:0] req0_addr_i,
  input  logic [DATA_WIDTH-1:0] req0_data_i,
  output logic                  res0_valid_o,
  input  logic                  res0_ready_i,
  output logic [DATA_WIDTH-1:0] res0_data_o,
  input  logic                  req1_valid_i,
  output logic                  req1_ready_o,
  input  logic                  req1_read_write_i,
  input  logic [BE_W-1:0]       req1_write_enable_i,
  input  logic [ADDR_WIDTH-1:0] req1_addr_i,
  input  logic [DATA_WIDTH-1:0] req1_data_i,
  output logic                  res1_valid_o,
  input  logic                  res1_ready_i,
  output logic [DATA_WIDTH-1:0] res1_data_o,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic                  mem_req_read_write_o,
  output logic [BE_W-1:0]       mem_req_write_enable_o,
  output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
  output logic [DATA_WIDTH-1:0] mem_req_data_o,
  input  logic                  mem_res_valid_i,
  output logic                  mem_res_ready_o,
  input  logic [DATA_WIDTH-1:0] mem_res_data_i,
  output logic [CNT_W-1:0]      outstanding_o,
  output logic                  protocol_error_o
);

  gecko_mem_arb_owner_t pick_w, grant_w;
  gecko_mem_arb_owner_t grant_q, grant_d;
  gecko_mem_arb_owner_t last_grant_q, last_grant_d;
  logic lock_q, lock_d;
  logic perr_q, perr_d;
  logic q_full_w, q_empty_w, q_head_w;
  logic granted_valid_w, accept_ready_w, req_hs_w, res_hs_w;

  always_comb begin
    pick_w = OWNER_PORT0;
    if (req0_valid_i && req1_valid_i) begin
      pick_w = (ARB_MODE == GECKO_MEM_ARB_FIXED) ? OWNER_PORT0 : ~last_grant_q;
    end else if (req1_valid_i) begin
      pick_w = OWNER_PORT1;
    end
  end

  // A presented-but-unaccepted request keeps the grant until its handshake
  assign grant_w         = lock_q ? grant_q : pick_w;
  assign granted_valid_w = (grant_w == OWNER_PORT1) ? req1_valid_i : req0_valid_i;
  assign accept_ready_w  = !rst && !q_full_w && mem_req_ready_i;

  assign mem_req_valid_o        = !rst && granted_valid_w && !q_full_w;
  assign mem_req_read_write_o   = (grant_w == OWNER_PORT1) ? req1_read_write_i   : req0_read_write_i;
  assign mem_req_write_enable_o = (grant_w == OWNER_PORT1) ? req1_write_enable_i : req0_write_enable_i;
  assign mem_req_addr_o         = (grant_w == OWNER_PORT1) ? req1_addr_i         : req0_addr_i;
  assign mem_req_data_o         = (grant_w == OWNER_PORT1) ? req1_data_i         : req0_data_i;
  assign req0_ready_o           = accept_ready_w && (grant_w == OWNER_PORT0);
  assign req1_ready_o           = accept_ready_w && (grant_w == OWNER_PORT1);
  assign req_hs_w               = mem_req_valid_o && mem_req_ready_i;

  assign res0_valid_o    = mem_res_valid_i && !q_empty_w && (q_head_w == OWNER_PORT0);
  assign res1_valid_o    = mem_res_valid_i && !q_empty_w && (q_head_w == OWNER_PORT1);
  assign res0_data_o     = mem_res_data_i;
  assign res1_data_o     = mem_res_data_i;
  assign mem_res_ready_o = !q_empty_w && ((q_head_w == OWNER_PORT1) ? res1_ready_i : res0_ready_i);
  assign res_hs_w        = mem_res_valid_i && mem_res_ready_o;

  always_comb begin
    lock_d       = lock_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    perr_d       = perr_q | (mem_res_valid_i && q_empty_w);
    if (req_hs_w) begin
      lock_d       = 1'b0;
      last_grant_d = grant_w;
    end else if (mem_req_valid_o) begin
      lock_d  = 1'b1;
      grant_d = grant_w;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q       <= 1'b0;
      grant_q      <= OWNER_PORT0;
      last_grant_q <= OWNER_PORT1;
      perr_q       <= 1'b0;
    end else begin
      lock_q       <= lock_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      perr_q       <= perr_d;
    end
  end

  assign protocol_error_o = perr_q;

  gecko_mem_arbiter_order_queue #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_order_queue (
    .clk     (clk),
    .rst     (rst),
    .push_i  (req_hs_w),
    .pop_i   (res_hs_w),
    .owner_i (grant_w),
    .head_o  (q_head_w),
    .empty_o (q_empty_w),
    .full_o  (q_full_w),
    .count_o (outstanding_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_gecko_mem_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_gecko_mem_arbiter : bench for the two-requester memory arbiter
// Rev 1.0
//------------------------------------------------------------------------------
module tb_gecko_mem_arbiter;
  import gecko_mem_arbiter_pkg::*;

  localparam int MO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        req0_valid_i, req0_ready_o, req0_read_write_i;
  logic [3:0]  req0_write_enable_i;
  logic [31:0] req0_addr_i, req0_data_i;
  logic        res0_valid_o, res0_ready_i;
  logic [31:0] res0_data_o;
  logic        req1_valid_i, req1_ready_o, req1_read_write_i;
  logic [3:0]  req1_write_enable_i;
  logic [31:0] req1_addr_i, req1_data_i;
  logic        res1_valid_o, res1_ready_i;
  logic [31:0] res1_data_o;
  logic        mem_req_valid_o, mem_req_ready_i, mem_req_read_write_o;
  logic [3:0]  mem_req_write_enable_o;
  logic [31:0] mem_req_addr_o, mem_req_data_o;
  logic        mem_res_valid_i, mem_res_ready_o;
  logic [31:0] mem_res_data_i;
  logic [2:0]  outstanding_o;
  logic        protocol_error_o;

  logic        fx_req0_ready, fx_req1_ready, fx_res0_valid, fx_res1_valid;
  logic [31:0] fx_res0_data, fx_res1_data, fx_addr, fx_wdata;
  logic        fx_mem_req_valid, fx_rw, fx_mem_res_ready, fx_perr;
  logic [3:0]  fx_be;
  logic [2:0]  fx_outstanding;

  gecko_mem_arbiter #(.MAX_OUTSTANDING(MO), .ARB_MODE(GECKO_MEM_ARB_ROUND_ROBIN)) dut (
    .clk(clk), .rst(rst),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_read_write_i(req0_read_write_i),
    .req0_write_enable_i(req0_write_enable_i), .req0_addr_i(req0_addr_i), .req0_data_i(req0_data_i),
    .res0_valid_o(res0_valid_o), .res0_ready_i(res0_ready_i), .res0_data_o(res0_data_o),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_read_write_i(req1_read_write_i),
    .req1_write_enable_i(req1_write_enable_i), .req1_addr_i(req1_addr_i), .req1_data_i(req1_data_i),
    .res1_valid_o(res1_valid_o), .res1_ready_i(res1_ready_i), .res1_data_o(res1_data_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_read_write_o(mem_req_read_write_o), .mem_req_write_enable_o(mem_req_write_enable_o),
    .mem_req_addr_o(mem_req_addr_o), .mem_req_data_o(mem_req_data_o),
    .mem_res_valid_i(mem_res_valid_i), .mem_res_ready_o(mem_res_ready_o), .mem_res_data_i(mem_res_data_i),
    .outstanding_o(outstanding_o), .protocol_error_o(protocol_error_o)
  );

  // Fixed-priority instance sees the same requests; its memory never answers
  gecko_mem_arbiter #(.MAX_OUTSTANDING(MO), .ARB_MODE(GECKO_MEM_ARB_FIXED)) dut_fx (
    .clk(clk), .rst(rst),
    .req0_valid_i(req0_valid_i), .req0_ready_o(fx_req0_ready), .req0_read_write_i(req0_read_write_i),
    .req0_write_enable_i(req0_write_enable_i), .req0_addr_i(req0_addr_i), .req0_data_i(req0_data_i),
    .res0_valid_o(fx_res0_valid), .res0_ready_i(1'b1), .res0_data_o(fx_res0_data),
    .req1_valid_i(req1_valid_i), .req1_ready_o(fx_req1_ready), .req1_read_write_i(req1_read_write_i),
    .req1_write_enable_i(req1_write_enable_i), .req1_addr_i(req1_addr_i), .req1_data_i(req1_data_i),
    .res1_valid_o(fx_res1_valid), .res1_ready_i(1'b1), .res1_data_o(fx_res1_data),
    .mem_req_valid_o(fx_mem_req_valid), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_read_write_o(fx_rw), .mem_req_write_enable_o(fx_be),
    .mem_req_addr_o(fx_addr), .mem_req_data_o(fx_wdata),
    .mem_res_valid_i(1'b0), .mem_res_ready_o(fx_mem_res_ready), .mem_res_data_i(32'h0),
    .outstanding_o(fx_outstanding), .protocol_error_o(fx_perr)
  );

  typedef struct { logic [31:0] addr; logic wr; logic [31:0] wdata; } rq_t;
  typedef struct { logic [31:0] data; int due; } pend_t;

  rq_t         rq0[$], rq1[$];
  pend_t       pend[$];
  bit          oq[$];
  bit          issued[$];
  logic [31:0] exp0[$], exp1[$];
  logic [31:0] mem [16];
  int          total = 0, bad = 0, cyc = 0, lat = 1;
  bit          last_m, held, held_owner, perr_m;
  bit          res_rdy0, res_rdy1, mem_rdy, inject;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void clear_model();
    rq0.delete(); rq1.delete(); pend.delete(); oq.delete(); issued.delete();
    exp0.delete(); exp1.delete();
    last_m = 1'b1; held = 1'b0; perr_m = 1'b0; inject = 1'b0;
  endfunction

  task automatic drive();
    req0_valid_i = rq0.size() > 0;
    req0_addr_i = req0_valid_i ? rq0[0].addr : 32'h0;
    req0_read_write_i = req0_valid_i ? rq0[0].wr : 1'b0;
    req0_data_i = req0_valid_i ? rq0[0].wdata : 32'h0;
    req0_write_enable_i = (req0_valid_i && rq0[0].wr) ? 4'hF : 4'h0;
    req1_valid_i = rq1.size() > 0;
    req1_addr_i = req1_valid_i ? rq1[0].addr : 32'h0;
    req1_read_write_i = req1_valid_i ? rq1[0].wr : 1'b0;
    req1_data_i = req1_valid_i ? rq1[0].wdata : 32'h0;
    req1_write_enable_i = (req1_valid_i && rq1[0].wr) ? 4'hF : 4'h0;
    res0_ready_i = res_rdy0;
    res1_ready_i = res_rdy1;
    mem_req_ready_i = mem_rdy;
    mem_res_valid_i = inject || (pend.size() > 0 && pend[0].due <= cyc);
    mem_res_data_i = (pend.size() > 0) ? pend[0].data : 32'hDEAD_BEEF;
  endtask

  // Spec-level model: grant rule, owner order queue, per-requester expected data
  task automatic model_step();
    bit v0, v1, g, full, exp_mv, any;
    rq_t r;
    logic [31:0] e;
    v0 = req0_valid_i; v1 = req1_valid_i;
    full = oq.size() >= MO;
    any = oq.size() > 0;
    if (held) g = held_owner;
    else if (v0 && v1) g = ~last_m;
    else g = v1;
    exp_mv = (g ? v1 : v0) && !full;
    chk("mem_req_valid", mem_req_valid_o, exp_mv);
    if (v0 || v1) begin
      chk("req0_ready", req0_ready_o, (g == 1'b0) && !full && mem_rdy);
      chk("req1_ready", req1_ready_o, (g == 1'b1) && !full && mem_rdy);
    end
    if (exp_mv) begin
      r = g ? rq1[0] : rq0[0];
      chk("mem_req_addr", mem_req_addr_o, r.addr);
      chk("mem_req_rw", mem_req_read_write_o, r.wr);
      chk("mem_req_be", mem_req_write_enable_o, r.wr ? 4'hF : 4'h0);
      chk("mem_req_data", mem_req_data_o, r.wdata);
    end
    chk("res0_valid", res0_valid_o, mem_res_valid_i && any && (oq[0] == 1'b0));
    chk("res1_valid", res1_valid_o, mem_res_valid_i && any && (oq[0] == 1'b1));
    chk("mem_res_ready", mem_res_ready_o, any && (oq[0] ? res_rdy1 : res_rdy0));
    chk("outstanding", outstanding_o, oq.size());
    chk("protocol_error", protocol_error_o, perr_m);

    if (mem_res_valid_i && !any) perr_m = 1'b1;
    if (mem_res_valid_i && mem_res_ready_o) begin
      if (pend.size() > 0 && !inject) void'(pend.pop_front());
      if (oq.size() > 0) begin
        if (oq.pop_front() == 1'b0) begin
          if (exp0.size() > 0) chk("res0_data", res0_data_o, exp0.pop_front());
        end else begin
          if (exp1.size() > 0) chk("res1_data", res1_data_o, exp1.pop_front());
        end
      end
    end
    if (mem_req_valid_o && mem_req_ready_i) begin
      if ((g ? rq1.size() : rq0.size()) > 0) begin
        r = g ? rq1[0] : rq0[0];
        e = r.wr ? r.wdata : mem[r.addr[5:2]];
        if (g) exp1.push_back(e); else exp0.push_back(e);
      end
      if (mem_req_read_write_o) mem[mem_req_addr_o[5:2]] = mem_req_data_o;
      pend.push_back('{data: mem[mem_req_addr_o[5:2]], due: cyc + lat});
      oq.push_back(g); issued.push_back(g);
      last_m = g; held = 1'b0;
      if (req0_valid_i && req0_ready_o) void'(rq0.pop_front());
      if (req1_valid_i && req1_ready_o) void'(rq1.pop_front());
    end else if (exp_mv && !mem_rdy) begin
      held = 1'b1; held_owner = g;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    drive();
    #1;
    if (!rst) model_step();
    cyc++;
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_mem_req_valid"}, mem_req_valid_o, 0);
    chk({tag, "_req0_ready"}, req0_ready_o, 0);
    chk({tag, "_req1_ready"}, req1_ready_o, 0);
    chk({tag, "_res0_valid"}, res0_valid_o, 0);
    chk({tag, "_res1_valid"}, res1_valid_o, 0);
    chk({tag, "_mem_res_ready"}, mem_res_ready_o, 0);
    chk({tag, "_outstanding"}, outstanding_o, 0);
    chk({tag, "_protocol_error"}, protocol_error_o, 0);
  endtask

  task automatic reset_all();
    rst = 1'b1;
    clear_model();
    cycle(); cycle();
    rst = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((rq0.size() + rq1.size() + oq.size() + pend.size()) > 0 && n < 300) begin
      cycle(); n++;
    end
    if (n >= 300) begin
      total++; bad++;
      $display("FAIL drain_timeout: got %0d cycles, required fewer than 300", n);
    end
    chk("scoreboard_empty", exp0.size() + exp1.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'hA000_0000 + i;
    res_rdy0 = 1'b1; res_rdy1 = 1'b1; mem_rdy = 1'b1;
    rst = 1'b1;
    clear_model();
    drive();
    cycle(); cycle();
    check_reset_outputs("reset");
    rst = 1'b0;

    // single requester, 1-cycle memory
    rq0.push_back('{addr: 32'h10, wr: 1'b0, wdata: 32'h0});
    cycle();
    chk("single_addr", mem_req_addr_o, 32'h10);
    chk("single_valid", mem_req_valid_o, 1);
    cycle();
    chk("single_res0_valid", res0_valid_o, 1);
    chk("single_res0_data", res0_data_o, 32'hA000_0004);
    chk("single_res1_valid", res1_valid_o, 0);
    drain();

    // both requesters every cycle: round-robin vs fixed instance
    reset_all();
    for (int i = 0; i < 4; i++) begin
      rq0.push_back('{addr: 32'(4 * i), wr: 1'b0, wdata: 32'h0});
      rq1.push_back('{addr: 32'(16 + 4 * i), wr: 1'b0, wdata: 32'h0});
    end
    for (int k = 0; k < 5; k++) begin
      cycle();
      if (k < 4) begin
        chk("fixed_req0_ready", fx_req0_ready, 1);
        chk("fixed_req1_ready", fx_req1_ready, 0);
        chk("fixed_addr", fx_addr, req0_addr_i);
      end else begin
        chk("fixed_full_valid", fx_mem_req_valid, 0);
        chk("fixed_full_count", fx_outstanding, 4);
      end
    end
    drain();
    chk("rr_issue_count", issued.size(), 8);
    for (int i = 0; i < 8 && i < issued.size(); i++)
      chk($sformatf("rr_order%0d", i), issued[i], i % 2);

    // memory stalls three cycles with both requesters waiting
    rq0.push_back('{addr: 32'h24, wr: 1'b0, wdata: 32'h0});
    rq1.push_back('{addr: 32'h28, wr: 1'b0, wdata: 32'h0});
    mem_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("stall_valid", mem_req_valid_o, 1);
      chk("stall_addr", mem_req_addr_o, 32'h24);
      chk("stall_req0_ready", req0_ready_o, 0);
      chk("stall_req1_ready", req1_ready_o, 0);
    end
    mem_rdy = 1'b1;
    cycle();
    chk("stall_release_req0", req0_ready_o, 1);
    chk("stall_release_req1", req1_ready_o, 0);
    drain();

    // order queue fills while requester 0 refuses results
    res_rdy0 = 1'b0;
    for (int i = 0; i < 6; i++) rq0.push_back('{addr: 32'(4 * i), wr: 1'b0, wdata: 32'h0});
    for (int k = 0; k < 6; k++) cycle();
    chk("full_outstanding", outstanding_o, 4);
    chk("full_req0_ready", req0_ready_o, 0);
    chk("full_mem_req_valid", mem_req_valid_o, 0);
    res_rdy0 = 1'b1;
    cycle();
    chk("full_pop_mem_res_ready", mem_res_ready_o, 1);
    chk("full_pop_req0_ready", req0_ready_o, 0);
    cycle();
    chk("full_resume_req0_ready", req0_ready_o, 1);
    chk("full_resume_outstanding", outstanding_o, 3);
    drain();

    // 2-cycle memory, interleaved traffic with a write
    lat = 2;
    rq0.push_back('{addr: 32'h30, wr: 1'b1, wdata: 32'hC0FF_EE01});
    for (int i = 0; i < 4; i++) begin
      rq0.push_back('{addr: 32'(8 * i), wr: 1'b0, wdata: 32'h0});
      rq1.push_back('{addr: 32'(8 * i + 4), wr: 1'b0, wdata: 32'h0});
    end
    rq1.push_back('{addr: 32'h30, wr: 1'b0, wdata: 32'h0});
    drain();
    chk("write_stored", mem[12], 32'hC0FF_EE01);

    // result with empty order queue
    inject = 1'b1;
    cycle();
    chk("orphan_mem_res_ready", mem_res_ready_o, 0);
    chk("orphan_res0_valid", res0_valid_o, 0);
    inject = 1'b0;
    cycle();
    chk("orphan_protocol_error", protocol_error_o, 1);
    cycle();
    chk("orphan_sticky", protocol_error_o, 1);

    // reset in the middle of traffic
    lat = 1;
    for (int i = 0; i < 4; i++) begin
      rq0.push_back('{addr: 32'(4 * i), wr: 1'b0, wdata: 32'h0});
      rq1.push_back('{addr: 32'(4 * i + 32), wr: 1'b0, wdata: 32'h0});
    end
    cycle(); cycle(); cycle();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    clear_model();
    cycle();
    rst = 1'b0;
    rq1.push_back('{addr: 32'h08, wr: 1'b0, wdata: 32'h0});
    drain();
    chk("post_reset_issue", issued.size(), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
